nn_accum_mem: RTL and testbench

NN_ACCUM_MEM -- requirements
Module: nn_accum_mem

---
 rtl/nn_pkg.sv | 9 +
 rtl/accum_bram.sv | 20 ++
 rtl/nn_accum_mem.sv | 130 +++++++++++++
 tb/tb_nn_accum_mem.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// nn_pkg: shared widths and FSM state type for the accumulation memory
package nn_pkg;
   localparam int LANE_W = 18;
   localparam int CT_W = 2 * LANE_W;
   localparam int IDX_K_W = 10;
   localparam int IDX_N_W = 10;
   localparam int IDX_W_W = 6;
   typedef enum logic [1:0] {ACCUM, DRAIN, DONE} state_t;
endpackage

// File: rtl/accum_bram.sv
// accum_bram: simple dual-port RAM, one clock, registered 1-cycle read
// ports: clk_in clock; we/wa/wd write port; ra read address; rd read data (valid the cycle after ra)
module accum_bram #(
   parameter int DEPTH = 16,
   parameter int AW = 4,
   parameter int DW = 36
) (
   input  logic          clk_in,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [DW-1:0] wd,
   input  logic [AW-1:0] ra,
   output logic [DW-1:0] rd
);
   logic [DW-1:0] mem [DEPTH];
   always_ff @(posedge clk_in) begin
      if (we) mem[wa] <= wd;
      rd <= mem[ra];
   end
endmodule

// File: rtl/nn_accum_mem.sv
// nn_accum_mem: partial-sum accumulation memory with read-back, final drain and done flag
// ports: clk_in/rst_in clock and async active-high reset
//        sum_valid/sum_ready/sum_in/sum_idx_{N,k,w} partial-sum write stream
//        mem_valid/mem_ready/mem_out previous partial sum read-back stream (zeros for pass 0)
//        res_valid/res_ready/res_out final results in address order; done after the last one
//        idx_err sticky index-mismatch flag, live only when NN_ACCUM_IDX_CHECK_EN is defined
module nn_accum_mem import nn_pkg::*; #(
   parameter int K_VAL = 501,
   parameter int DEPTH = 100,
   parameter int OUT_NODES = 10
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               sum_valid,
   input  logic [CT_W-1:0]    sum_in,
   input  logic [IDX_K_W-1:0] sum_idx_k,
   input  logic [IDX_N_W-1:0] sum_idx_N,
   input  logic [IDX_W_W-1:0] sum_idx_w,
   output logic               sum_ready,
   output logic               mem_valid,
   output logic [CT_W-1:0]    mem_out,
   input  logic               mem_ready,
   output logic               res_valid,
   output logic [CT_W-1:0]    res_out,
   input  logic               res_ready,
   output logic               done,
   output logic               idx_err
);
   localparam int E = K_VAL * OUT_NODES;
   localparam int AW = E > 1 ? $clog2(E) : 1;
   localparam int T = DEPTH * E;
   localparam int CW = $clog2(T + E + 1);
   localparam logic [CW-1:0] T_C = CW'(T);
   localparam logic [CW-1:0] E_C = CW'(E);
   state_t state;
   logic [CW-1:0] wc, rc, xc, ic;
   logic [AW-1:0] ra, rd_addr, wa;
   logic [CT_W-1:0] rd_data, p_d, h_d, t_d;
   logic p_v, p_z, h_v, t_v, wr, q, iss, last_wr;
   logic [1:0] occ;
   accum_bram #(.DEPTH(E), .AW(AW), .DW(CT_W)) u_ram (
      .clk_in(clk_in), .we(wr), .wa(wa), .wd(sum_in), .ra(rd_addr), .rd(rd_data)
   );
   // p_* is the RAM output stage, h_*/t_* the 2-entry skid; head drives both output streams.
   // ic is the next flat index to fetch: handshaked count plus entries already in flight.
   always_comb begin
      sum_ready = state == ACCUM;
      mem_valid = h_v && state == ACCUM;
      res_valid = h_v && state == DRAIN;
      done = state == DONE;
      mem_out = h_d;
      res_out = h_d;
      wr = sum_valid && sum_ready;
      q = (mem_valid && mem_ready) || (res_valid && res_ready);
      occ = {1'b0, p_v} + {1'b0, h_v} + {1'b0, t_v};
      ic = (state == DRAIN ? xc : rc) + CW'(occ);
      iss = (occ < 2'd2 || q) && (state == ACCUM ? (ic < T_C && (ic < E_C || wc + E_C > ic)) : (state == DRAIN && ic < E_C));
      rd_addr = state == DRAIN ? AW'(ic) : ra;
      wa = AW'(32'(sum_idx_k) * OUT_NODES + 32'(sum_idx_w));
      last_wr = wr && wc == T_C - 1'b1;
      p_d = p_z ? '0 : rd_data;
   end
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state <= ACCUM;
         wc <= '0;
         rc <= '0;
         xc <= '0;
         ra <= '0;
         p_v <= 1'b0;
         p_z <= 1'b0;
         h_v <= 1'b0;
         t_v <= 1'b0;
         h_d <= '0;
         t_d <= '0;
      end else begin
         if (wr) wc <= wc + 1'b1;
         if (mem_valid && mem_ready) rc <= rc + 1'b1;
         if (res_valid && res_ready) xc <= xc + 1'b1;
         if (iss && state == ACCUM) ra <= ra == AW'(E - 1) ? '0 : ra + 1'b1;
         p_v <= iss;
         p_z <= state == ACCUM && ic < E_C;
         if (q) begin
            h_v <= t_v | p_v;
            if (t_v | p_v) h_d <= t_v ? t_d : p_d;
            t_v <= t_v & p_v;
            if (t_v & p_v) t_d <= p_d;
         end else if (p_v) begin
            if (h_v) begin
               t_v <= 1'b1;
               t_d <= p_d;
            end else begin
               h_v <= 1'b1;
               h_d <= p_d;
            end
         end
         // unconsumed read-backs are dropped when the last sum lands
         if (last_wr) begin
            state <= DRAIN;
            p_v <= 1'b0;
            h_v <= 1'b0;
            t_v <= 1'b0;
         end else if (res_valid && res_ready && xc == E_C - 1'b1) state <= DONE;
      end
   end
`ifdef NN_ACCUM_IDX_CHECK_EN
   logic [IDX_N_W-1:0] e_n;
   logic [IDX_K_W-1:0] e_k;
   logic [IDX_W_W-1:0] e_w;
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         e_n <= '0;
         e_k <= '0;
         e_w <= '0;
         idx_err <= 1'b0;
      end else if (wr) begin
         if ({sum_idx_N, sum_idx_k, sum_idx_w} != {e_n, e_k, e_w}) idx_err <= 1'b1;
         e_w <= e_w == IDX_W_W'(OUT_NODES - 1) ? '0 : e_w + 1'b1;
         if (e_w == IDX_W_W'(OUT_NODES - 1)) begin
            e_k <= e_k == IDX_K_W'(K_VAL - 1) ? '0 : e_k + 1'b1;
            if (e_k == IDX_K_W'(K_VAL - 1)) e_n <= e_n + 1'b1;
         end
      end
   end
`else
   logic unused_idx;
   assign unused_idx = ^sum_idx_N;
   assign idx_err = 1'b0;
`endif
endmodule

// File: tb/tb_nn_accum_mem.sv
// tb_nn_accum_mem: directed and randomized check of nn_accum_mem against a flat-index reference model
module tb_nn_accum_mem;
   import nn_pkg::*;
   localparam int K = 2;
   localparam int D = 2;
   localparam int O = 2;
   localparam int E = K * O;
   localparam int T = D * E;
`ifdef NN_ACCUM_IDX_CHECK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif
   logic clk_in = 1'b0;
   logic rst_in = 1'b1;
   logic sum_valid = 1'b0;
   logic mem_ready = 1'b0;
   logic res_ready = 1'b0;
   logic [CT_W-1:0] sum_in = '0;
   logic [IDX_K_W-1:0] sum_idx_k = '0;
   logic [IDX_N_W-1:0] sum_idx_N = '0;
   logic [IDX_W_W-1:0] sum_idx_w = '0;
   logic sum_ready, mem_valid, res_valid, done, idx_err;
   logic [CT_W-1:0] mem_out, res_out;
   int total = 0;
   int bad = 0;
   int wr_m = 0;
   int rd_m = 0;
   int xc_m = 0;
   logic [CT_W-1:0] sum_f [T];
   always #5 clk_in = ~clk_in;
   nn_accum_mem #(.K_VAL(K), .DEPTH(D), .OUT_NODES(O)) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .sum_valid(sum_valid), .sum_in(sum_in), .sum_idx_k(sum_idx_k), .sum_idx_N(sum_idx_N),
      .sum_idx_w(sum_idx_w), .sum_ready(sum_ready),
      .mem_valid(mem_valid), .mem_out(mem_out), .mem_ready(mem_ready),
      .res_valid(res_valid), .res_out(res_out), .res_ready(res_ready),
      .done(done), .idx_err(idx_err)
   );
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask
   function automatic logic [63:0] exp_mem(input int f);
      return f < E ? 64'd0 : 64'(sum_f[f-E]);
   endfunction
   task automatic check_reset();
      chk("rst_sum_ready", 64'(sum_ready), 64'd1);
      chk("rst_mem_valid", 64'(mem_valid), 64'd0);
      chk("rst_res_valid", 64'(res_valid), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_idx_err", 64'(idx_err), 64'd0);
      chk("rst_mem_out", 64'(mem_out), 64'd0);
      chk("rst_res_out", 64'(res_out), 64'd0);
   endtask
   task automatic do_reset();
      rst_in = 1'b1;
      sum_valid = 1'b0;
      mem_ready = 1'b0;
      res_ready = 1'b0;
      #1;
      check_reset();
      tick();
      rst_in = 1'b0;
      wr_m = 0;
      rd_m = 0;
      xc_m = 0;
   endtask
   // upstream model: a sum for flat index f is only sent once its read-back f has been taken
   task automatic run_accum(input int wt, input int rt, input int maxc, input bit rnd);
      bit pend = 1'b0;
      bit hw, hr;
      logic [CT_W-1:0] pd = '0;
      for (int c = 0; c < maxc && (wr_m < wt || rd_m < rt); c++) begin
         sum_valid = wr_m < wt && rd_m > wr_m && (!rnd || $urandom_range(0, 3) != 0);
         sum_in = sum_f[wr_m % T];
         sum_idx_N = 10'(wr_m / E);
         sum_idx_k = 10'((wr_m % E) / O);
         sum_idx_w = 6'(wr_m % O);
         mem_ready = rd_m < rt && (!rnd || $urandom_range(0, 3) != 0);
         if (pend) begin
            chk("mem_hold_v", 64'(mem_valid), 64'd1);
            chk("mem_hold_d", 64'(mem_out), 64'(pd));
         end
         if (mem_valid) chk("mem_hazard", 64'(rd_m < E || wr_m > rd_m - E), 64'd1);
         if (sum_valid) chk("sum_ready", 64'(sum_ready), 64'd1);
         if (mem_valid && mem_ready) chk("mem_data", 64'(mem_out), exp_mem(rd_m));
         hw = sum_valid && sum_ready;
         hr = mem_valid && mem_ready;
         pend = mem_valid && !mem_ready;
         pd = mem_out;
         tick();
         wr_m += int'(hw);
         rd_m += int'(hr);
      end
      sum_valid = 1'b0;
      mem_ready = 1'b0;
      chk("accum_bound", 64'(wr_m >= wt && rd_m >= rt), 64'd1);
   endtask
   // mode 0: ready held high, 1: toggled every cycle, 2: random
   task automatic run_drain(input int mode, input int maxc);
      bit pend = 1'b0;
      bit hs;
      logic [CT_W-1:0] pd = '0;
      for (int c = 0; c < maxc && done !== 1'b1; c++) begin
         res_ready = mode == 0 ? 1'b1 : mode == 1 ? c[0] : 1'($urandom_range(0, 1));
         if (pend) begin
            chk("res_hold_v", 64'(res_valid), 64'd1);
            chk("res_hold_d", 64'(res_out), 64'(pd));
         end
         if (res_valid) chk("res_extra", 64'(xc_m < E), 64'd1);
         if (res_valid && res_ready && xc_m < E) chk("res_data", 64'(res_out), 64'(sum_f[(D-1)*E + xc_m]));
         hs = res_valid && res_ready;
         pend = res_valid && !res_ready;
         pd = res_out;
         tick();
         xc_m += int'(hs);
      end
      res_ready = 1'b1;
      chk("res_count", 64'(xc_m), 64'(E));
      chk("done", 64'(done), 64'd1);
      chk("done_sum_ready", 64'(sum_ready), 64'd0);
      chk("done_res_valid", 64'(res_valid), 64'd0);
      chk("done_mem_valid", 64'(mem_valid), 64'd0);
      chk("done_idx_err", 64'(idx_err), 64'd0);
      tick();
      chk("done_sticky", 64'(done), 64'd1);
      chk("done_no_res", 64'(res_valid), 64'd0);
      res_ready = 1'b0;
   endtask
   initial begin
      do_reset();
      // zeros served for pass 0, then the hazard stalls the read stream
      run_accum(0, 4, 10, 1'b0);
      mem_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         chk("pass0_stall", 64'(mem_valid), 64'd0);
         tick();
      end
      mem_ready = 1'b0;
      chk("pass0_reads", 64'(rd_m), 64'd4);
      for (int i = 0; i < E; i++) begin
         sum_f[i] = CT_W'(i + 1);
         sum_f[E + i] = CT_W'(10 * (i + 1));
      end
      run_accum(4, 8, 40, 1'b0);
      run_accum(8, 8, 40, 1'b0);
      chk("drain_sum_ready", 64'(sum_ready), 64'd0);
      chk("drain_mem_valid", 64'(mem_valid), 64'd0);
      run_drain(0, 40);
      // reset in the middle of a pass
      do_reset();
      sum_f[0] = 36'd5;
      sum_f[1] = 36'd6;
      sum_f[2] = 36'd7;
      run_accum(3, 4, 30, 1'b0);
      #2;
      rst_in = 1'b1;
      #1;
      check_reset();
      tick();
      rst_in = 1'b0;
      wr_m = 0;
      rd_m = 0;
      xc_m = 0;
      run_accum(0, 4, 10, 1'b0);
      for (int i = 0; i < T; i++) sum_f[i] = {4'($urandom), $urandom};
      run_accum(8, 8, 400, 1'b1);
      run_drain(1, 40);
      do_reset();
      for (int i = 0; i < T; i++) sum_f[i] = {4'($urandom), $urandom};
      run_accum(8, 8, 400, 1'b1);
      run_drain(2, 200);
      // index mismatch on the first write
      do_reset();
      sum_valid = 1'b1;
      sum_in = 36'h1;
      sum_idx_N = '0;
      sum_idx_k = '0;
      sum_idx_w = 6'd1;
      tick();
      sum_valid = 1'b0;
      chk("idx_err_set", 64'(idx_err), 64'(EXP_ERR));
      tick();
      tick();
      chk("idx_err_sticky", 64'(idx_err), 64'(EXP_ERR));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
